// File: rtl/axis_sched_pkg.sv
// rtl/axis_sched_pkg.sv - shared state encodings and width helper for the stream schedulers
package axis_sched_pkg;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ID   = 5'b00010,
        S_ADDR = 5'b00100,
        S_LEN  = 5'b01000,
        S_GAP  = 5'b10000
    } sched_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_write_sched_if.sv
// rtl/axis_write_sched_if.sv - requester, config-bus and completion signals of the write scheduler
interface axis_write_sched_if #(
    parameter int NREQ       = 4,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_DWIDTH = 32
);
    import axis_sched_pkg::*;

    localparam int GW = idx_width(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*CFG_DWIDTH-1:0] req_addr;
    logic [NREQ*CFG_DWIDTH-1:0] req_len;
    logic [CFG_AWIDTH-1:0]      cfg_addr;
    logic [CFG_DWIDTH-1:0]      cfg_data;
    logic                       cfg_valid;
    logic                       xfer_done;
    logic [GW-1:0]              grant_id;
    logic [3:0]                 outstanding;
    logic                       busy;
    logic                       err_done;

    modport master (
        input  req_valid, req_addr, req_len, xfer_done,
        output req_ready, cfg_addr, cfg_data, cfg_valid, grant_id, outstanding, busy, err_done
    );

    modport slave (
        output req_valid, req_addr, req_len, xfer_done,
        input  req_ready, cfg_addr, cfg_data, cfg_valid, grant_id, outstanding, busy, err_done
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first requester at or after the pointer wins
module rr_arbiter
    import axis_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_o
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        logic        found;
        logic [IW:0] cand;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!found && req_i[cand[IW-1:0]]) begin
                found                  = 1'b1;
                grant_o[cand[IW-1:0]]  = 1'b1;
                grant_idx_o            = cand[IW-1:0];
            end
        end
    end

    assign any_o = |req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i && any_o) begin
            ptr_q <= (grant_idx_o == IW'(NREQ-1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/axis_write_sched.sv
// rtl/axis_write_sched.sv - replays granted {addr,len} descriptors as ID/addr/len config words
module axis_write_sched
    import axis_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CFG_ID     = 1,
    parameter int CFG_ADDR   = 23,
    parameter int CFG_DATA   = 24,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_GAP    = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_write_sched_if.master     bus
);

    localparam int GW  = idx_width(NREQ);
    localparam int GCW = $clog2(CFG_GAP);

    sched_state_e          state_q;
    logic [CFG_DWIDTH-1:0] addr_q, len_q;
    logic [GCW-1:0]        gap_q;
    logic [3:0]            out_q, out_d;
    logic [NREQ-1:0]       req_ready_q;
    logic                  cfg_valid_q;
    logic [CFG_AWIDTH-1:0] cfg_addr_q;
    logic [CFG_DWIDTH-1:0] cfg_data_q;
    logic [GW-1:0]         grant_id_q;
    logic                  busy_q, err_q;

    logic [NREQ-1:0]       grant;
    logic [GW-1:0]         gidx;
    logic                  any_req, can_grant, inc, err_set, active_d;
    logic [CFG_DWIDTH-1:0] sel_addr, sel_len;

    assign can_grant = (state_q == S_IDLE) && any_req && (out_q < 4'(MAX_OUT));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req_valid),
        .advance_i   (can_grant),
        .grant_o     (grant),
        .grant_idx_o (gidx),
        .any_o       (any_req)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == GW'(i)) begin
                sel_addr = bus.req_addr[i*CFG_DWIDTH +: CFG_DWIDTH];
                sel_len  = bus.req_len[i*CFG_DWIDTH +: CFG_DWIDTH];
            end
        end
    end

    // A completion that coincides with the issuing S_LEN cancels the increment.
    assign inc     = (state_q == S_LEN);
    assign err_set = bus.xfer_done && !inc && (out_q == 4'd0);

    always_comb begin
        out_d = out_q;
        if (inc && !bus.xfer_done)
            out_d = out_q + 4'd1;
        else if (!inc && bus.xfer_done && out_q != 4'd0)
            out_d = out_q - 4'd1;
    end

    always_comb begin
        active_d = 1'b1;
        unique case (state_q)
            S_IDLE:  active_d = can_grant && (sel_len != '0);
            S_GAP:   active_d = (gap_q != '0);
            default: active_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            out_q       <= '0;
            req_ready_q <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            out_q       <= out_d;
            busy_q      <= active_d || (out_d != 4'd0);
            if (err_set) err_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (can_grant) begin
                        req_ready_q <= grant;
                        grant_id_q  <= gidx;
                        addr_q      <= sel_addr;
                        len_q       <= sel_len;
                        if (sel_len != '0) state_q <= S_ID;
                    end
                end
                S_ID: begin
                    cfg_valid_q <= 1'b1;
                    cfg_addr_q  <= CFG_AWIDTH'(CFG_ADDR);
                    cfg_data_q  <= CFG_DWIDTH'(CFG_ID);
                    state_q     <= S_ADDR;
                end
                S_ADDR: begin
                    cfg_valid_q <= 1'b1;
                    cfg_addr_q  <= CFG_AWIDTH'(CFG_DATA);
                    cfg_data_q  <= addr_q;
                    state_q     <= S_LEN;
                end
                S_LEN: begin
                    cfg_valid_q <= 1'b1;
                    cfg_addr_q  <= CFG_AWIDTH'(CFG_DATA);
                    cfg_data_q  <= len_q;
                    gap_q       <= GCW'(CFG_GAP - 1);
                    state_q     <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q == '0) state_q <= S_IDLE;
                    else             gap_q   <= gap_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.cfg_valid   = cfg_valid_q;
    assign bus.cfg_addr    = cfg_addr_q;
    assign bus.cfg_data    = cfg_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.outstanding = out_q;
    assign bus.busy        = busy_q;
    assign bus.err_done    = err_q;

endmodule

// File: tb/tb_axis_write_sched.sv
// tb/tb_axis_write_sched.sv - directed bench for axis_write_sched (MAX_OUT=2 and MAX_OUT=15 instances)
module tb_axis_write_sched;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    axis_write_sched_if #(.NREQ(4), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) ifa ();
    axis_write_sched_if #(.NREQ(4), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) ifb ();

    axis_write_sched #(.NREQ(4), .CFG_GAP(4), .MAX_OUT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    axis_write_sched #(.NREQ(4), .CFG_GAP(4), .MAX_OUT(15)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_a(input int i, input logic [31:0] a, input logic [31:0] l);
        case (i)
            0: begin ifa.req_addr[31:0]   = a; ifa.req_len[31:0]   = l; end
            1: begin ifa.req_addr[63:32]  = a; ifa.req_len[63:32]  = l; end
            2: begin ifa.req_addr[95:64]  = a; ifa.req_len[95:64]  = l; end
            default: begin ifa.req_addr[127:96] = a; ifa.req_len[127:96] = l; end
        endcase
    endtask

    task automatic chk_cfg(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, 32'(ifa.cfg_valid), 32'(v));
        chk({tag, "_addr"},  32'(ifa.cfg_addr),  a);
        chk({tag, "_data"},  ifa.cfg_data,       d);
    endtask

    initial begin
        int n;
        int ng;
        int order [2];

        rst = 1'b1;
        ifa.req_valid = '0; ifa.req_addr = '0; ifa.req_len = '0; ifa.xfer_done = 1'b0;
        ifb.req_valid = '0; ifb.req_addr = '0; ifb.req_len = '0; ifb.xfer_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk_cfg("rst_cfg", 1'b0, 32'd0, 32'd0);
        chk("rst_ready", 32'(ifa.req_ready),   32'd0);
        chk("rst_out",   32'(ifa.outstanding), 32'd0);
        chk("rst_busy",  32'(ifa.busy),        32'd0);
        chk("rst_err",   32'(ifa.err_done),    32'd0);
        chk("rst_gid",   32'(ifa.grant_id),    32'd0);
        chk("rst_b_busy", 32'(ifb.busy),       32'd0);
        rst = 1'b0;

        // Single request: three words then a gap
        set_a(0, 32'h1000, 32'd64);
        ifa.req_valid = 4'b0001;
        tick();
        chk("t1_ready", 32'(ifa.req_ready), 32'h1);
        chk("t1_busy",  32'(ifa.busy),      32'd1);
        chk("t1_grant_cycle_cfg", 32'(ifa.cfg_valid), 32'd0);
        ifa.req_valid = '0;
        tick();
        chk_cfg("t1_id", 1'b1, 32'd23, 32'd1);
        chk("t1_ready_pulse", 32'(ifa.req_ready), 32'd0);
        tick();
        chk_cfg("t1_addr", 1'b1, 32'd24, 32'h1000);
        tick();
        chk_cfg("t1_len", 1'b1, 32'd24, 32'd64);
        chk("t1_out", 32'(ifa.outstanding), 32'd1);
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_cfg("t1_gap", 1'b0, 32'd0, 32'd0);
        end

        ifa.xfer_done = 1'b1;
        tick();
        ifa.xfer_done = 1'b0;
        chk("t1_done_out", 32'(ifa.outstanding), 32'd0);
        chk("t1_done_err", 32'(ifa.err_done),    32'd0);

        // Zero-length descriptor is consumed without config words
        set_a(1, 32'h5555, 32'd0);
        ifa.req_valid = 4'b0010;
        tick();
        chk("t5_ready", 32'(ifa.req_ready), 32'h2);
        chk("t5_gid",   32'(ifa.grant_id),  32'd1);
        ifa.req_valid = '0;
        tick();
        chk("t5_cfg_valid", 32'(ifa.cfg_valid),   32'd0);
        chk("t5_out",       32'(ifa.outstanding), 32'd0);
        chk("t5_busy",      32'(ifa.busy),        32'd0);
        tick();
        chk("t5_cfg_valid2", 32'(ifa.cfg_valid), 32'd0);

        // Completion with nothing outstanding
        ifa.xfer_done = 1'b1;
        tick();
        ifa.xfer_done = 1'b0;
        chk("t5_err", 32'(ifa.err_done),    32'd1);
        chk("t5_err_out", 32'(ifa.outstanding), 32'd0);

        // MAX_OUT=2 with three requests, pointer at 2
        set_a(0, 32'h1100, 32'd8);
        set_a(1, 32'h2000, 32'd16);
        set_a(2, 32'h3000, 32'd32);
        ifa.req_valid = 4'b0111;
        ng = 0;
        order[0] = -1;
        order[1] = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ifa.req_ready != '0) begin
                if (ng < 2) order[ng] = int'(ifa.grant_id);
                ng++;
                ifa.req_valid = ifa.req_valid & ~ifa.req_ready;
            end
        end
        chk("t3_ngrants", 32'(ng),       32'd2);
        chk("t3_first",   32'(order[0]), 32'd2);
        chk("t3_second",  32'(order[1]), 32'd0);
        chk("t3_out",     32'(ifa.outstanding), 32'd2);
        chk("t3_pending", 32'(ifa.req_valid),   32'h2);

        ifa.xfer_done = 1'b1;
        tick();
        ifa.xfer_done = 1'b0;
        chk("t3_out_dec", 32'(ifa.outstanding), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.req_ready == '0 && n < 2);
        chk("t3_release_ready", 32'(ifa.req_ready), 32'h2);
        chk("t3_release_gid",   32'(ifa.grant_id),  32'd1);
        ifa.req_valid = '0;
        tick();
        chk_cfg("t3_id", 1'b1, 32'd23, 32'd1);
        tick();
        chk_cfg("t3_addr", 1'b1, 32'd24, 32'h2000);

        // Completion lands in the same cycle as the issuing length word
        ifa.xfer_done = 1'b1;
        tick();
        ifa.xfer_done = 1'b0;
        chk_cfg("t4_len", 1'b1, 32'd24, 32'd16);
        chk("t4_out", 32'(ifa.outstanding), 32'd1);

        ifa.xfer_done = 1'b1;
        tick();
        ifa.xfer_done = 1'b0;
        chk("t6_pre_out", 32'(ifa.outstanding), 32'd0);

        // Reset in the middle of a sequence; pointer returns to 0
        set_a(3, 32'h4000, 32'd4);
        ifa.req_valid = 4'b1110;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.req_ready == '0 && n < 12);
        chk("t6_ready", 32'(ifa.req_ready), 32'h4);
        ifa.req_valid = 4'b1010;
        tick();
        chk_cfg("t6_id", 1'b1, 32'd23, 32'd1);
        rst = 1'b1;
        tick();
        chk_cfg("t6_rst_cfg", 1'b0, 32'd0, 32'd0);
        chk("t6_rst_ready", 32'(ifa.req_ready),   32'd0);
        chk("t6_rst_gid",   32'(ifa.grant_id),    32'd0);
        chk("t6_rst_out",   32'(ifa.outstanding), 32'd0);
        chk("t6_rst_busy",  32'(ifa.busy),        32'd0);
        chk("t6_rst_err",   32'(ifa.err_done),    32'd0);
        rst = 1'b0;
        tick();
        chk("t6_regrant_ready", 32'(ifa.req_ready), 32'h2);
        chk("t6_regrant_gid",   32'(ifa.grant_id),  32'd1);
        ifa.req_valid = '0;

        // All four requesting with MAX_OUT=15: strict rotation, 8 cycles apart
        ifb.req_addr  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        ifb.req_len   = {32'd4, 32'd3, 32'd2, 32'd1};
        ifb.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (ifb.req_ready == '0 && n < 20);
            chk($sformatf("t2_ready%0d", k), 32'(ifb.req_ready), 32'(1 << (k % 4)));
            chk($sformatf("t2_gid%0d", k),   32'(ifb.grant_id),  32'(k % 4));
            if (k > 0) chk($sformatf("t2_period%0d", k), 32'(n), 32'd8);
        end
        ifb.req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
